// File: rtl/magma_pkg.sv
// Shared definitions for the Magma (GOST R 34.12-2015, 64-bit) block cipher engine:
// tc26 S-boxes, rotate amount, FSM state encoding and round-key selection.
package magma_pkg;

   localparam int ROT = 11;

   // Row j is the substitution for nibble j (bits 4j+3:4j) of the round sum.
   localparam logic [3:0] SBOX [8][16] = '{
      '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
      '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
      '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
      '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
      '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
      '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
      '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
      '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Returns the 0-based key word index (0 = K1) for round rnd.
   // Encrypt: K1..K8 x3 then K8..K1; decrypt: K1..K8 then K8..K1 x3.
   function automatic logic [2:0] key_idx(input logic [4:0] rnd, input logic dec);
      logic fwd;
      fwd = dec ? (rnd < 5'd8) : (rnd < 5'd24);
      return fwd ? rnd[2:0] : ~rnd[2:0];
   endfunction

endpackage

// File: rtl/magma_round.sv
// One combinational Magma Feistel round: R' = L ^ rotl11(S(R + K)), L' = R.
module magma_round
   import magma_pkg::*;
(
   input  logic [31:0] l_in,
   input  logic [31:0] r_in,
   input  logic [31:0] k_in,
   output logic [31:0] l_out,
   output logic [31:0] r_out
);

   logic [31:0] sum;
   logic [31:0] sub;

   assign sum = r_in + k_in;

   always_comb begin
      sub = '0;
      for (int j = 0; j < 8; j++) begin
         sub[4*j +: 4] = SBOX[j][sum[4*j +: 4]];
      end
   end

   assign r_out = l_in ^ ((sub << ROT) | (sub >> (32 - ROT)));
   assign l_out = r_in;

endmodule

// File: rtl/magma_cipher_engine.sv
// Iterative Magma encrypt/decrypt engine: UNROLL rounds per RUN cycle,
// valid/ready on both the block input and the result output.
module magma_cipher_engine
   import magma_pkg::*;
#(
   parameter int UNROLL    = 1,
   parameter int KEY_LATCH = 1
) (
   input  logic         clk,
   input  logic         reset_,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         decrypt,
   input  logic [63:0]  data_in,
   input  logic [255:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  data_out,
   output logic         busy,
   output logic [1:0]   state_dbg
);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready.
   // out_valid/data_out stay stable from assertion until that transfer.

   state_t       state, state_nx;
   logic [31:0]  l_q, r_q;
   logic [4:0]   cnt;
   logic         dec_q;
   logic [255:0] key_q;
   logic [255:0] key_use;
   logic         accept;

   logic [31:0]  l_c [UNROLL+1];
   logic [31:0]  r_c [UNROLL+1];

   assign accept    = in_valid && in_ready;
   assign key_use   = (KEY_LATCH != 0) ? key_q : key;
   assign state_dbg = state;
   assign l_c[0]    = l_q;
   assign r_c[0]    = r_q;

   for (genvar i = 0; i < UNROLL; i++) begin : g_round
      logic [4:0]  rnd;
      logic [2:0]  kidx;
      logic [31:0] kw;
      assign rnd  = cnt + 5'(i);
      assign kidx = key_idx(rnd, dec_q);
      assign kw   = key_use[{~kidx, 5'd0} +: 32];
      magma_round u_round (
         .l_in  (l_c[i]),
         .r_in  (r_c[i]),
         .k_in  (kw),
         .l_out (l_c[i+1]),
         .r_out (r_c[i+1])
      );
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (cnt == 5'(32 - UNROLL)) state_nx = ST_DONE;
         end
         ST_DONE: begin
            if (out_valid && out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state     <= ST_IDLE;
         l_q       <= '0;
         r_q       <= '0;
         cnt       <= '0;
         dec_q     <= 1'b0;
         key_q     <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  l_q   <= data_in[63:32];
                  r_q   <= data_in[31:0];
                  cnt   <= '0;
                  dec_q <= decrypt;
                  key_q <= key;
               end
            end
            ST_RUN: begin
               l_q <= l_c[UNROLL];
               r_q <= r_c[UNROLL];
               cnt <= cnt + 5'(UNROLL);
            end
            ST_DONE: begin
               // First DONE cycle publishes the block with the last swap undone.
               if (!out_valid) begin
                  data_out  <= {r_q, l_q};
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_magma_cipher_engine.sv
// Scoreboard bench: four engines (UNROLL 1,2,4,8) share stimulus; a negedge
// monitor checks each result and its latency against queued expectations.
module tb_magma_cipher_engine;

   localparam int N = 4;
   localparam logic [255:0] KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [63:0]  PT  = 64'hfedcba9876543210;
   localparam logic [63:0]  CT  = 64'h4ee901e5c2d8ca3d;

   logic         clk = 1'b0;
   logic         reset_ = 1'b0;
   logic         in_valid = 1'b0;
   logic         decrypt = 1'b0;
   logic [63:0]  data_in = '0;
   logic [255:0] key = '0;
   logic         out_ready = 1'b1;

   logic         in_ready_w  [N];
   logic         out_valid_w [N];
   logic [63:0]  data_out_w  [N];
   logic         busy_w      [N];
   logic [1:0]   state_w     [N];

   logic [63:0]  exp_q [N][$];
   int           lat_q [N][$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int accept_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : g_dut
      magma_cipher_engine #(.UNROLL(1 << g), .KEY_LATCH(1)) dut (
         .clk       (clk),
         .reset_    (reset_),
         .in_valid  (in_valid),
         .in_ready  (in_ready_w[g]),
         .decrypt   (decrypt),
         .data_in   (data_in),
         .key       (key),
         .out_valid (out_valid_w[g]),
         .out_ready (out_ready),
         .data_out  (data_out_w[g]),
         .busy      (busy_w[g]),
         .state_dbg (state_w[g])
      );
   end

   task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s u%0d act=%h exp=%h", name, 1 << inst, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one block to all engines at once; optionally scramble inputs right after accept.
   task automatic issue(input logic dec, input logic [63:0] din, input logic [63:0] exp, input bit scramble);
      int  n;
      bit  all_rdy;
      n = 0;
      all_rdy = 1'b0;
      while (!all_rdy && n < 200) begin
         all_rdy = 1'b1;
         for (int k = 0; k < N; k++) if (!in_ready_w[k]) all_rdy = 1'b0;
         if (!all_rdy) begin tick(); n++; end
      end
      chk("issue_ready_timeout", 0, 64'(all_rdy), 64'd1);
      if (!all_rdy) return;
      in_valid = 1'b1;
      decrypt  = dec;
      data_in  = din;
      key      = KEY;
      for (int k = 0; k < N; k++) begin
         exp_q[k].push_back(exp);
         lat_q[k].push_back(32 / (1 << k) + 1);
      end
      tick();
      accept_cyc = cyc;
      in_valid = 1'b0;
      for (int k = 0; k < N; k++) chk("busy_after_accept", k, 64'(busy_w[k]), 64'd1);
      if (scramble) begin
         data_in = 64'h0123456789abcdef;
         key     = ~KEY;
         decrypt = ~dec;
      end
   endtask

   task automatic drain();
      int  n;
      bit  pend;
      n = 0;
      pend = 1'b1;
      while (pend && n < 200) begin
         pend = 1'b0;
         for (int k = 0; k < N; k++) if (exp_q[k].size() != 0) pend = 1'b1;
         if (pend) begin tick(); n++; end
      end
      chk("drain_timeout", 0, 64'(pend), 64'd0);
   endtask

   task automatic check_idle(input string name);
      for (int k = 0; k < N; k++) begin
         chk({name, "_in_ready"}, k, 64'(in_ready_w[k]), 64'd1);
         chk({name, "_out_valid"}, k, 64'(out_valid_w[k]), 64'd0);
         chk({name, "_busy"}, k, 64'(busy_w[k]), 64'd0);
      end
   endtask

   // Monitor: latency on out_valid rise, stability under stall, data on handshake.
   logic        prev_ov [N];
   logic [63:0] prev_do [N];
   logic        prev_ordy = 1'b0;
   initial for (int k = 0; k < N; k++) begin prev_ov[k] = 1'b0; prev_do[k] = '0; end

   always @(negedge clk) begin
      if (reset_) begin
         for (int k = 0; k < N; k++) begin
            if (out_valid_w[k] && !prev_ov[k]) begin
               chk("unexpected_out_valid", k, 64'(lat_q[k].size() != 0), 64'd1);
               if (lat_q[k].size() != 0) chk("latency", k, 64'(cyc - accept_cyc), 64'(lat_q[k].pop_front()));
            end
            if (out_valid_w[k] && prev_ov[k] && !prev_ordy) chk("stall_stable", k, data_out_w[k], prev_do[k]);
            if (out_valid_w[k]) chk("in_ready_while_done", k, 64'(in_ready_w[k]), 64'd0);
            if (out_valid_w[k] && out_ready && exp_q[k].size() != 0)
               chk("data_out", k, data_out_w[k], exp_q[k].pop_front());
            prev_ov[k] = out_valid_w[k];
            prev_do[k] = data_out_w[k];
         end
      end else begin
         for (int k = 0; k < N; k++) prev_ov[k] = 1'b0;
      end
      prev_ordy = out_ready;
   end

   initial begin
      int n;
      bit all_ov;

      // Reset values, then first cycle after release
      repeat (3) tick();
      for (int k = 0; k < N; k++) chk("reset_data_out", k, data_out_w[k], 64'd0);
      reset_ = 1'b1;
      #1;
      check_idle("post_reset");

      // Encrypt / decrypt known-answer vectors, then back-to-back
      issue(1'b0, PT, CT, 1'b0);
      drain();
      issue(1'b1, CT, PT, 1'b0);
      drain();
      issue(1'b0, PT, CT, 1'b0);
      issue(1'b1, CT, PT, 1'b0);
      drain();

      // Backpressure: hold out_ready low 10 cycles after all results are up
      out_ready = 1'b0;
      issue(1'b0, PT, CT, 1'b0);
      n = 0;
      all_ov = 1'b0;
      while (!all_ov && n < 100) begin
         tick();
         n++;
         all_ov = 1'b1;
         for (int k = 0; k < N; k++) if (!out_valid_w[k]) all_ov = 1'b0;
      end
      chk("stall_wait_timeout", 0, 64'(all_ov), 64'd1);
      repeat (10) tick();
      out_ready = 1'b1;
      tick();
      check_idle("after_release");
      drain();

      // Reset at RUN cycle 15 aborts; the next block completes normally
      issue(1'b0, PT, CT, 1'b0);
      repeat (14) tick();
      reset_ = 1'b0;
      for (int k = 0; k < N; k++) begin
         exp_q[k].delete();
         lat_q[k].delete();
      end
      tick();
      for (int k = 0; k < N; k++) chk("midrun_reset_data_out", k, data_out_w[k], 64'd0);
      reset_ = 1'b1;
      #1;
      check_idle("after_midrun_reset");
      issue(1'b0, PT, CT, 1'b0);
      drain();

      // Inputs changed the cycle after accept must not disturb the result
      issue(1'b0, PT, CT, 1'b1);
      drain();
      issue(1'b1, CT, PT, 1'b1);
      drain();

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/magma_cipher_engine.md
MAGMA_CIPHER_ENGINE -- requirements
Module: magma_cipher_engine

Interface
REQ-001 SHALL have parameter UNROLL, default 1: rounds computed per clock, legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter KEY_LATCH, default 1: 1 = key captured at accept, 0 = key used live.
REQ-003 clk  input  1  clock, rising edge.
REQ-004 reset_  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  block and key on the data inputs are valid.
REQ-006 in_ready  output  1  engine can accept a block.
REQ-007 decrypt  input  1  0 = encrypt, 1 = decrypt; sampled at accept.
REQ-008 data_in  input  64  input block; [63:32] is the left half (a1).
REQ-009 key  input  256  cipher key; K1 = key[255:224] … K8 = key[31:0].
REQ-010 out_valid  output  1  data_out holds a result.
REQ-011 out_ready  input  1  consumer accepts data_out.
REQ-012 data_out  output  64  result block.
REQ-013 busy  output  1  high in RUN state.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE -> RUN on accept; RUN -> DONE when the final round completes; DONE -> IDLE when out_valid && out_ready.
REQ-015 SHALL drive in_ready = 1 only in IDLE; accept = in_valid && in_ready.
REQ-016 At accept SHALL load L = data_in[63:32], R = data_in[31:0], round counter = 0, and latch decrypt (and key when KEY_LATCH = 1).
REQ-017 Each RUN cycle SHALL apply UNROLL rounds, each round: R' = L xor rotl11(S(R + Kr mod 2^32)), L' = R.
REQ-018 S SHALL apply the tc26 S-box j to nibble j (bits 4j+3:4j) of the 32-bit sum.
REQ-019 Encrypt key order SHALL be K1..K8 three times, then K8..K1.
REQ-020 Decrypt key order SHALL be K1..K8 once, then K8..K1 three times.
REQ-021 The round counter SHALL be 5-bit and advance by UNROLL per cycle; RUN SHALL last exactly 32/UNROLL cycles.
REQ-022 On leaving RUN, SHALL register data_out = {R, L} (final swap undone) and assert out_valid the next cycle.
REQ-023 Latency from accept edge to out_valid high SHALL be 32/UNROLL + 1 cycles.
REQ-024 Under backpressure, data_out and out_valid SHALL hold stable until out_ready.
REQ-025 in_valid is ignored outside IDLE; no block is ever dropped or duplicated.
REQ-026 Changing data_in or key after accept SHALL NOT affect the result when KEY_LATCH = 1.

Reset
REQ-027 Asserting reset_ SHALL force IDLE, out_valid = 0, busy = 0, data_out = 0, L = R = 0, counter = 0.
REQ-028 After reset release, in_ready = 1 on the first cycle.
REQ-029 Reset mid-operation SHALL abort the computation with no out_valid pulse.

Structure
REQ-030 magma_pkg SHALL hold the 8x16 tc26 S-box table, the rotate constant 11, the FSM state enum, and the key-schedule index function.
REQ-031 A combinational sub-module magma_round (inputs L, R, Kr; outputs L', R') SHALL be instantiated UNROLL times in a chain.

Verification
REQ-032 Encrypt, key ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, data fedcba9876543210 -> data_out 4ee901e5c2d8ca3d, out_valid at 33 cycles (UNROLL=1).
REQ-033 Decrypt with the same key, data 4ee901e5c2d8ca3d -> data_out fedcba9876543210.
REQ-034 out_ready held low for 10 cycles after out_valid -> data_out stable, in_ready = 0 throughout; release -> IDLE next cycle.
REQ-035 reset_ pulsed low at RUN cycle 15, then the REQ-032 vector applied -> no stale out_valid, then the correct result.
REQ-036 Regress REQ-032/033 with UNROLL = 2, 4, 8 -> identical results, latency 17, 9, 5 cycles.
REQ-037 Key and data changed on the cycle after accept (KEY_LATCH = 1) -> result still 4ee901e5c2d8ca3d.
